uart_tx_arbiter: RTL and testbench

- Shares the single uarttx transmitter between NUM_REQ byte sources, e.g. the CPU SNDA path and a debug/monitor source.
- Grants one requester at a time, latches its byte and drives the tx_start/tx_byte handshake.
- Tracks uarttx tx_ready through a full busy-then-idle cycle and reports completion per requester.
- Sits between the requesters and the uarttx instance, in the same clock and reset domain.

---
 rtl/uart_arb_pkg.sv | 20 ++
 rtl/uart_arb_select.sv | 44 ++++
 rtl/uart_tx_arbiter.sv | 114 +++++++++++
 tb/tb_uart_tx_arbiter.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the uarttx arbiter: FSM state encoding,
// timer width and index-width helper.
package uart_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT_BUSY,
        WAIT_DONE
    } arb_state_t;

    localparam int unsigned BUSY_TIMEOUT_DEF = 16;
    localparam int unsigned TMR_W            = $clog2(BUSY_TIMEOUT_DEF);

    // Width of an index into n items; never narrower than one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_arb_select.sv
// Combinational winner select: round robin from last+1 by default,
// lowest asserted index when UART_ARB_FIXED_PRIO_EN is defined.
module uart_arb_select
    import uart_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]        req,
    input  logic [idx_w(NUM_REQ)-1:0] last,
    output logic [idx_w(NUM_REQ)-1:0] winner,
    output logic                      valid
);

    localparam int unsigned IW = idx_w(NUM_REQ);

`ifdef UART_ARB_FIXED_PRIO_EN
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!valid && req[IW'(i)]) begin
                winner = IW'(i);
                valid  = 1'b1;
            end
        end
    end
`else
    always_comb begin
        logic [IW-1:0] idx;
        idx    = '0;
        winner = '0;
        valid  = 1'b0;
        // Scan last+1, last+2, ... wrapping, so the last winner is checked last.
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            idx = IW'((32'(last) + i) % NUM_REQ);
            if (!valid && req[idx]) begin
                winner = idx;
                valid  = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uarttx transmitter between NUM_REQ byte sources.
// Define UART_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins).
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ      = 2,
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned BUSY_TIMEOUT = 16
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]         ack,
    output logic [NUM_REQ-1:0]         done,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy,
    output logic                       timeout_err,
    output logic                       tx_start,
    output logic [WIDTH-1:0]           tx_byte,
    input  logic                       tx_ready
);

    localparam int unsigned   IW       = idx_w(NUM_REQ);
    localparam int unsigned   TW       = idx_w(BUSY_TIMEOUT);
    localparam logic [TW-1:0] TMO_LAST = TW'(BUSY_TIMEOUT - 1);

    arb_state_t    state;
    logic [TW-1:0] timer;
    logic [IW-1:0] last;
    logic [IW-1:0] sel_winner;
    logic          sel_valid;
    logic          xfer_end;

    uart_arb_select #(
        .NUM_REQ (NUM_REQ)
    ) u_select (
        .req    (req),
        .last   (last),
        .winner (sel_winner),
        .valid  (sel_valid)
    );

    // Transfer finishes on tx_ready rising after busy, or on busy never appearing.
    assign xfer_end = tx_ready &&
                      ((state == WAIT_DONE) || (state == WAIT_BUSY && timer == TMO_LAST));

`ifdef UART_ARB_FIXED_PRIO_EN
    assign last = IW'(NUM_REQ - 1);
`else
    always_ff @(posedge clk) begin
        if (!rstn) begin
            last <= IW'(NUM_REQ - 1);
        end else if (xfer_end) begin
            last <= grant_id;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state       <= IDLE;
            timer       <= '0;
            ack         <= '0;
            done        <= '0;
            tx_start    <= 1'b0;
            tx_byte     <= '0;
            grant_id    <= '0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            ack      <= '0;
            done     <= '0;
            tx_start <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (tx_ready && sel_valid) begin
                        tx_byte  <= req_data[32'(sel_winner)*WIDTH +: WIDTH];
                        grant_id <= sel_winner;
                        ack      <= NUM_REQ'(1) << sel_winner;
                        tx_start <= 1'b1;
                        busy     <= 1'b1;
                        state    <= START;
                    end
                end
                START: begin
                    timer <= '0;
                    state <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (!tx_ready) begin
                        state <= WAIT_DONE;
                    end else if (xfer_end) begin
                        done        <= NUM_REQ'(1) << grant_id;
                        timeout_err <= 1'b1;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (xfer_end) begin
                        done  <= NUM_REQ'(1) << grant_id;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized bench for uart_tx_arbiter: stubbed uarttx with scheduled busy
// windows, random requesters, and a transaction-level expectation model.
module tb_uart_tx_arbiter;

    localparam int unsigned N      = 3;
    localparam int unsigned W      = 8;
    localparam int unsigned BT     = 16;
    localparam int unsigned IW     = $clog2(N);
    localparam int unsigned CYCLES = 4000;

    logic           clk = 1'b0;
    logic           rstn;
    logic [N-1:0]   req;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   ack;
    logic [N-1:0]   done;
    logic [IW-1:0]  grant_id;
    logic           busy;
    logic           timeout_err;
    logic           tx_start;
    logic [W-1:0]   tx_byte;
    logic           tx_ready;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NUM_REQ      (N),
        .WIDTH        (W),
        .BUSY_TIMEOUT (BT)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .req         (req),
        .req_data    (req_data),
        .ack         (ack),
        .done        (done),
        .grant_id    (grant_id),
        .busy        (busy),
        .timeout_err (timeout_err),
        .tx_start    (tx_start),
        .tx_byte     (tx_byte),
        .tx_ready    (tx_ready)
    );

    int unsigned n_total = 0;
    int unsigned n_bad   = 0;
    int          cyc     = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            if (n_bad <= 40)
                $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, got, exp);
        end
    endtask

    // Priority order: distance from the last served index, counted cyclically.
    function automatic int pick(input logic [N-1:0] r, input int lst);
        int best = -1;
        int bd   = N;
`ifdef UART_ARB_FIXED_PRIO_EN
        for (int i = N - 1; i >= 0; i--)
            if (r[i]) best = i;
`else
        for (int i = 0; i < N; i++) begin
            int d;
            d = (i - lst - 1 + 2 * N) % N;
            if (r[i] && d < bd) begin
                bd   = d;
                best = i;
            end
        end
`endif
        return best;
    endfunction

    // Model state
    int           m_last, m_gid, free_from, done_cyc, low_lo, low_hi;
    int           granted, w, f, len, resets;
    bit           inflight, m_tmo, m_terr, force_all;
    logic [W-1:0] m_byte;
    logic [N-1:0] e_ack, e_done;
    bit           e_start;
    logic [N-1:0] p_req;
    logic [N*W-1:0] p_data;
    bit           p_ready, p_rstn;

    initial begin
        rstn = 1'b0; req = '0; req_data = '0; tx_ready = 1'b1;
        p_req = '0; p_data = '0; p_ready = 1'b1; p_rstn = 1'b0;
        m_last = N - 1; m_gid = 0; m_byte = '0; m_terr = 0; m_tmo = 0;
        inflight = 0; free_from = 0; done_cyc = -1; low_lo = -1; low_hi = -2;
        resets = 0; force_all = 0;

        repeat (CYCLES) begin
            @(negedge clk);
            cyc++;
            e_ack = '0; e_done = '0; e_start = 0; granted = -1;

            if (!p_rstn) begin
                inflight = 0; m_last = N - 1; m_terr = 0; m_gid = 0;
                m_byte = '0; free_from = cyc;
            end else if (inflight && cyc == done_cyc) begin
                e_done[m_gid] = 1'b1;
                m_last   = m_gid;
                if (m_tmo) m_terr = 1;
                inflight = 0;
                free_from = cyc;
            end else if (!inflight && cyc - 1 >= free_from && p_ready && p_req != '0) begin
                w = pick(p_req, m_last);
                granted  = w;
                e_ack[w] = 1'b1;
                e_start  = 1;
                m_gid    = w;
                m_byte   = p_data[w*W +: W];
                inflight = 1;
            end

            chk("ack",         32'(ack),         32'(e_ack));
            chk("done",        32'(done),        32'(e_done));
            chk("tx_start",    32'(tx_start),    32'(e_start));
            chk("busy",        32'(busy),        32'(inflight));
            chk("grant_id",    32'(grant_id),    m_gid);
            chk("tx_byte",     32'(tx_byte),     32'(m_byte));
            chk("timeout_err", 32'(timeout_err), 32'(m_terr));

            // Stub uarttx: either never goes busy, or busy for a random window.
            if (granted >= 0) begin
                if ($urandom_range(7) == 0) begin
                    m_tmo = 1; low_lo = -1; low_hi = -2;
                    done_cyc = cyc + BT + 1;
                end else begin
                    m_tmo = 0;
                    f   = $urandom_range(3);
                    len = $urandom_range(5, 1);
                    low_lo   = cyc + 1 + f;
                    low_hi   = cyc + f + len;
                    done_cyc = cyc + f + len + 2;
                end
            end

            rstn = 1'b1;
            if (inflight && !m_tmo && cyc > low_lo && cyc < done_cyc &&
                resets < 4 && $urandom_range(9) == 0) begin
                rstn = 1'b0;
                resets++;
            end

            if (inflight && cyc >= low_lo && cyc <= low_hi)
                tx_ready = 1'b0;
            else if (!inflight && !force_all)
                tx_ready = ($urandom_range(9) != 0);
            else
                tx_ready = 1'b1;

            if (!rstn || force_all) begin
                req = '1;
                force_all = !rstn;
            end else begin
                for (int i = 0; i < N; i++) begin
                    if (req[i])
                        req[i] = (granted == i) ? ($urandom_range(1) == 1) : ($urandom_range(9) != 0);
                    else
                        req[i] = ($urandom_range(9) < 3);
                end
            end
            for (int i = 0; i < N; i++)
                req_data[i*W +: W] = W'($urandom);

            p_req = req; p_data = req_data; p_ready = tx_ready; p_rstn = rstn;
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
